// File: rtl/toy_bpu_tage_base_mem_if.sv
// ---------------------------------------------------------------------------
// toy_bpu_tage_base_mem_if
// Request/acknowledge bundle for the TAGE base-predictor table memory.
//   master modport (requester): drives mem_req_*, observes mem_ack_*, init_busy
//   slave  modport (memory)   : observes mem_req_*, drives mem_ack_*, init_busy
// Signals:
//   mem_req_vld   request valid, one request per cycle
//   mem_req_wren  1 = write, 0 = read (qualified by mem_req_vld)
//   mem_req_addr  entry index (ADDR_WIDTH)
//   mem_req_wdata write data (DATA_WIDTH)
//   mem_ack_rdata registered read data (DATA_WIDTH)
//   mem_ack_vld   one-cycle pulse marking a fresh read result
//   init_busy     high while the table init sweep runs
// ---------------------------------------------------------------------------
`ifndef TAGE_BASE_INDEX_WIDTH
`define TAGE_BASE_INDEX_WIDTH 4
`endif
`ifndef TAGE_BASE_PRED_WIDTH
`define TAGE_BASE_PRED_WIDTH 2
`endif

interface toy_bpu_tage_base_mem_if #(
    parameter int ADDR_WIDTH = `TAGE_BASE_INDEX_WIDTH,
    parameter int DATA_WIDTH = `TAGE_BASE_PRED_WIDTH
);
    logic                  mem_req_vld;
    logic                  mem_req_wren;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic [DATA_WIDTH-1:0] mem_req_wdata;
    logic [DATA_WIDTH-1:0] mem_ack_rdata;
    logic                  mem_ack_vld;
    logic                  init_busy;

    modport master (
        output mem_req_vld,
        output mem_req_wren,
        output mem_req_addr,
        output mem_req_wdata,
        input  mem_ack_rdata,
        input  mem_ack_vld,
        input  init_busy
    );

    modport slave (
        input  mem_req_vld,
        input  mem_req_wren,
        input  mem_req_addr,
        input  mem_req_wdata,
        output mem_ack_rdata,
        output mem_ack_vld,
        output init_busy
    );
endinterface

// File: rtl/toy_bpu_tage_base_mem.sv
// ---------------------------------------------------------------------------
// toy_bpu_tage_base_mem
// Single-port flop-based table for the TAGE base predictor. One access
// (read or write) per cycle; reads return one cycle later on mem_ack_*.
// Ports:
//   clk      single clock, rising edge
//   rst_n    asynchronous active-low reset
//   mem_bus  slave side of toy_bpu_tage_base_mem_if (request/ack/init_busy)
// Configuration:
//   TOY_BPU_TAGE_BASE_MEM_INIT_EN - when defined, an init sweep writes
//   INIT_VALUE to every entry after reset (one entry per cycle) and holds
//   off requests via init_busy. When undefined, there is no sweep, init_busy
//   is 0 and the table contents are undefined until written.
// Reset clears the ack outputs and the sweep counter; it never touches the
// table contents themselves.
// ---------------------------------------------------------------------------
`ifndef TAGE_BASE_INDEX_WIDTH
`define TAGE_BASE_INDEX_WIDTH 4
`endif
`ifndef TAGE_BASE_PRED_WIDTH
`define TAGE_BASE_PRED_WIDTH 2
`endif

module toy_bpu_tage_base_mem #(
    parameter int                    ADDR_WIDTH = `TAGE_BASE_INDEX_WIDTH,
    parameter int                    DATA_WIDTH = `TAGE_BASE_PRED_WIDTH,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = {DATA_WIDTH{1'b0}}
) (
    input  logic                         clk,
    input  logic                         rst_n,
    toy_bpu_tage_base_mem_if.slave       mem_bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  busy_s;
    logic                  rd_acc_s;
    logic                  wr_acc_s;
    logic                  arr_we_s;
    logic [ADDR_WIDTH-1:0] arr_waddr_s;
    logic [DATA_WIDTH-1:0] arr_wdata_s;

    logic                  ack_vld_q;
    logic                  ack_vld_d;
    logic [DATA_WIDTH-1:0] ack_rdata_q;
    logic [DATA_WIDTH-1:0] ack_rdata_d;

`ifdef TOY_BPU_TAGE_BASE_MEM_INIT_EN
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] IDX_MAX = {ADDR_WIDTH{1'b1}};

    state_e                state_q;
    state_e                state_d;
    logic [ADDR_WIDTH-1:0] init_idx_q;
    logic [ADDR_WIDTH-1:0] init_idx_d;
    logic                  init_wr_s;

    // Sweep state and index registers; reset restarts the sweep from index 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_idx_q <= {ADDR_WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
        end
    end

    // Sweep next-state: one entry per cycle, index saturates at the top entry.
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        init_wr_s  = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_wr_s = 1'b1;
                if (init_idx_q == IDX_MAX) begin
                    state_d = ST_IDLE;
                end else begin
                    init_idx_d = init_idx_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_INIT;
                init_idx_d = {ADDR_WIDTH{1'b0}};
            end
        endcase
    end

    // init_busy follows the state register directly, so it is high in reset.
    assign busy_s = (state_q == ST_INIT);
`else
    logic                  init_wr_s;
    logic [ADDR_WIDTH-1:0] init_idx_q;

    assign busy_s     = 1'b0;
    assign init_wr_s  = 1'b0;
    assign init_idx_q = {ADDR_WIDTH{1'b0}};
`endif

    // Requests arriving during the sweep are dropped outright.
    assign rd_acc_s = mem_bus.mem_req_vld & ~busy_s & ~mem_bus.mem_req_wren;
    assign wr_acc_s = mem_bus.mem_req_vld & ~busy_s &  mem_bus.mem_req_wren;

    // Single write port arbitration: the sweep owns the port while busy.
    always_comb begin
        arr_we_s    = 1'b0;
        arr_waddr_s = {ADDR_WIDTH{1'b0}};
        arr_wdata_s = {DATA_WIDTH{1'b0}};
        if (init_wr_s) begin
            arr_we_s    = 1'b1;
            arr_waddr_s = init_idx_q;
            arr_wdata_s = INIT_VALUE;
        end else if (wr_acc_s) begin
            arr_we_s    = 1'b1;
            arr_waddr_s = mem_bus.mem_req_addr;
            arr_wdata_s = mem_bus.mem_req_wdata;
        end else begin
            arr_we_s    = 1'b0;
        end
    end

    // Table storage; deliberately not reset so only the sweep initialises it.
    always_ff @(posedge clk) begin
        if (arr_we_s) begin
            mem_q[arr_waddr_s] <= arr_wdata_s;
        end
    end

    // Ack next-state: read data is captured on an accepted read, else held.
    always_comb begin
        ack_vld_d   = rd_acc_s;
        ack_rdata_d = ack_rdata_q;
        if (rd_acc_s) begin
            ack_rdata_d = mem_q[mem_bus.mem_req_addr];
        end else begin
            ack_rdata_d = ack_rdata_q;
        end
    end

    // Ack output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_vld_q   <= 1'b0;
            ack_rdata_q <= {DATA_WIDTH{1'b0}};
        end else begin
            ack_vld_q   <= ack_vld_d;
            ack_rdata_q <= ack_rdata_d;
        end
    end

    assign mem_bus.mem_ack_vld   = ack_vld_q;
    assign mem_bus.mem_ack_rdata = ack_rdata_q;
    assign mem_bus.init_busy     = busy_s;

endmodule

// File: tb/tb_toy_bpu_tage_base_mem.sv
// ---------------------------------------------------------------------------
// tb_toy_bpu_tage_base_mem
// Directed plus random bench for toy_bpu_tage_base_mem (ADDR_WIDTH=4,
// DATA_WIDTH=2, INIT_VALUE=2'b01). The expected table is a plain array that
// is updated from the request stream; the expected ack is "last read value".
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_toy_bpu_tage_base_mem;

    localparam int         AW     = 4;
    localparam int         DW     = 2;
    localparam int         DEPTH  = 16;
    localparam logic [1:0] INIT_V = 2'b01;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    toy_bpu_tage_base_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    toy_bpu_tage_base_mem #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .INIT_VALUE (INIT_V)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mem_bus (bus)
    );

    int         errors = 0;
    int         checks = 0;
    logic [1:0] model_mem [DEPTH];
    logic [1:0] exp_rdata = 2'b00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One post-init bus cycle: drive request, cross one rising edge, check ack.
    task automatic cycle(input string tag, input logic vld, input logic wren,
                         input logic [3:0] addr, input logic [1:0] wdata);
        logic exp_vld;
        bus.mem_req_vld   = vld;
        bus.mem_req_wren  = wren;
        bus.mem_req_addr  = addr;
        bus.mem_req_wdata = wdata;
        exp_vld = vld & ~wren;
        if (vld && wren)  model_mem[addr] = wdata;
        if (vld && !wren) exp_rdata = model_mem[addr];
        @(negedge clk);
        chk({tag, ".vld"},   32'(bus.mem_ack_vld),   32'(exp_vld));
        chk({tag, ".rdata"}, 32'(bus.mem_ack_rdata), 32'(exp_rdata));
        chk({tag, ".busy"},  32'(bus.init_busy),     32'(1'b0));
    endtask

    task automatic check_reset(input string tag, input logic exp_busy);
        exp_rdata = 2'b00;
        chk({tag, ".vld"},   32'(bus.mem_ack_vld),   32'(1'b0));
        chk({tag, ".rdata"}, 32'(bus.mem_ack_rdata), 32'(2'b00));
        chk({tag, ".busy"},  32'(bus.init_busy),     32'(exp_busy));
    endtask

`ifdef TOY_BPU_TAGE_BASE_MEM_INIT_EN
    // Count busy cycles after reset release while hammering reads of addr 3.
    task automatic wait_init(input string tag);
        int n;
        n = 0;
        bus.mem_req_vld  = 1'b1;
        bus.mem_req_wren = 1'b0;
        bus.mem_req_addr = 4'd3;
        for (int k = 0; k < 64; k++) begin
            if (bus.init_busy !== 1'b1) break;
            n++;
            @(negedge clk);
            chk({tag, ".drop_vld"},   32'(bus.mem_ack_vld),   32'(1'b0));
            chk({tag, ".drop_rdata"}, 32'(bus.mem_ack_rdata), 32'(2'b00));
        end
        bus.mem_req_vld = 1'b0;
        chk({tag, ".busy_cycles"}, 32'(n), 32'd16);
        for (int i = 0; i < DEPTH; i++) model_mem[i] = INIT_V;
    endtask
`endif

    initial begin
        bus.mem_req_vld   = 1'b0;
        bus.mem_req_wren  = 1'b0;
        bus.mem_req_addr  = 4'd0;
        bus.mem_req_wdata = 2'b00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

`ifdef TOY_BPU_TAGE_BASE_MEM_INIT_EN
        check_reset("reset", 1'b1);
        rst_n = 1'b1;
        wait_init("init1");
        for (int i = 0; i < DEPTH; i++) cycle("readinit", 1'b1, 1'b0, 4'(i), 2'b00);
        cycle("idle_after_init", 1'b0, 1'b0, 4'd0, 2'b00);
`else
        check_reset("reset", 1'b0);
        rst_n = 1'b1;
        cycle("first_wr", 1'b1, 1'b1, 4'd0, 2'b10);
        cycle("first_rd", 1'b1, 1'b0, 4'd0, 2'b00);
        for (int i = 0; i < DEPTH; i++)
            cycle("fill", 1'b1, 1'b1, 4'(i), 2'($urandom_range(0, 3)));
`endif

        // Write then immediately read the same entry.
        cycle("wr5",   1'b1, 1'b1, 4'd5, 2'b11);
        cycle("rd5",   1'b1, 1'b0, 4'd5, 2'b00);
        cycle("hold5", 1'b0, 1'b0, 4'd0, 2'b00);

        // Back-to-back reads then hold.
        cycle("wr1",   1'b1, 1'b1, 4'd1, 2'b10);
        cycle("wr2",   1'b1, 1'b1, 4'd2, 2'b00);
        cycle("rd1a",  1'b1, 1'b0, 4'd1, 2'b00);
        cycle("rd2",   1'b1, 1'b0, 4'd2, 2'b00);
        cycle("rd1b",  1'b1, 1'b0, 4'd1, 2'b00);
        cycle("hold1", 1'b0, 1'b0, 4'd0, 2'b00);
        cycle("hold2", 1'b0, 1'b1, 4'd1, 2'b11);

        // Random traffic against the array model.
        for (int i = 0; i < 300; i++)
            cycle("rand", ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));

        // Leave a non-zero value in the read register before resetting.
        cycle("wr7", 1'b1, 1'b1, 4'd7, 2'b11);
        cycle("rd7", 1'b1, 1'b0, 4'd7, 2'b00);
        bus.mem_req_vld = 1'b0;
        rst_n = 1'b0;
        #1;
`ifdef TOY_BPU_TAGE_BASE_MEM_INIT_EN
        check_reset("reset2", 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (9) @(negedge clk);
        chk("mid_sweep_busy", 32'(bus.init_busy), 32'(1'b1));
        rst_n = 1'b0;
        #1;
        check_reset("reset3", 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("init3");
        for (int i = 0; i < DEPTH; i++) cycle("readinit3", 1'b1, 1'b0, 4'(i), 2'b00);
`else
        check_reset("reset2", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        // Table contents survive reset when there is no sweep.
        cycle("rd7_after_rst", 1'b1, 1'b0, 4'd7, 2'b00);
        cycle("rd5_after_rst", 1'b1, 1'b0, 4'd5, 2'b00);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
